mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the core's single 16-bit memory port between the instruction-fetch requester (ProgramCounter side) and the load/store requester (LSU side). Word accesses are sequenced as two halfword beats and byte/half accesses get lane enables. Loads are sign- or zero-extended. Misaligned data accesses are rejected. The block sits between the core datapath and the external memory, and replaces the direct combinational instruction lookup.

## Interface
- LSU_PRIORITY, default 1: when both requesters are pending in IDLE, 1 = LSU wins, 0 = fetch wins.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-low reset.
- FetchReq  in  1  fetch request; held until FetchValid.
- FetchAddr  in  32  halfword-aligned fetch address; stable while FetchReq is high.
- FetchGnt  out  1  one-cycle pulse when the fetch is selected.
- FetchValid  out  1  one-cycle pulse; FetchData is valid.
- FetchData  out  16  fetched halfword.
- LsuReq  in  1  data request; held until LsuDone.
- LsuWrite  in  1  1 = store, 0 = load.
- LsuWidth  in  2  01 = LSW word, 10 = LSH half, 11 = LSB byte. 00 (LSN) is never requested.
- LsuUnsigned  in  1  zero-extend loads when 1, sign-extend when 0.
- LsuAddr  in  32  byte address.
- LsuWData  in  32  store data, right-aligned.
- LsuGnt  out  1  one-cycle pulse when the data access is selected.
- LsuDone  out  1  one-cycle completion pulse.
- LsuErr  out  1  valid with LsuDone; 1 = misaligned, no memory access made.
- LsuRData  out  32  extended load data; valid with LsuDone on loads.
- MemReq  out  1  memory request; held until MemReady.
- MemWrite  out  1  request is a write.
- MemAddr  out  32  halfword address, bit 0 always 0.
- MemByteEn  out  2  lane enables: [0] = low byte, [1] = high byte.
- MemWData  out  16  write data.
- MemReady  in  1  request accepted this cycle.
- MemRValid  in  1  read data valid. At most one read is outstanding.
- MemRData  in  16  read data.

## Operation
- States: IDLE, FETCH_REQ, FETCH_WAIT, LO_REQ, LO_WAIT, HI_REQ, HI_WAIT, DONE.
- IDLE: sample the requests and arbitrate per LSU_PRIORITY. The winner gets a Gnt pulse. Fetch goes to FETCH_REQ; a data access goes to LO_REQ. A misaligned data access instead goes to DONE with LsuErr = 1.
- Misaligned conditions:
  - word: LsuAddr[1:0] != 0
  - half: LsuAddr[0] != 0
  - byte: never misaligned.
- FETCH_REQ: MemReq = 1, MemWrite = 0, MemByteEn = 11, MemAddr = FetchAddr. On MemReady go to FETCH_WAIT.
- FETCH_WAIT: on MemRValid, register MemRData into FetchData, pulse FetchValid next cycle, and return to IDLE.
- LO_REQ, MemAddr = {LsuAddr[31:1],0}:
  - word: MemByteEn = 11, MemWData = LsuWData[15:0].
  - half: MemByteEn = 11, MemWData = LsuWData[15:0].
  - byte: MemByteEn = LsuAddr[0] ? 10 : 01, MemWData = {LsuWData[7:0], LsuWData[7:0]}.
- On MemReady in LO_REQ:
  - word write: go to HI_REQ.
  - half/byte write: go to DONE.
  - read: go to LO_WAIT.
- LO_WAIT: on MemRValid, capture the low beat. Word goes to HI_REQ; half/byte goes to DONE.
- HI_REQ: MemAddr = LsuAddr + 2, MemByteEn = 11, MemWData = LsuWData[31:16]. On MemReady, a write goes to DONE and a read goes to HI_WAIT.
- HI_WAIT: on MemRValid, capture the high beat and go to DONE.
- DONE: pulse LsuDone (LsuErr as decided) and drive LsuRData, then return to IDLE.
- LsuRData formation:
  - word: {hi, lo}.
  - half: lo extended from bit 15.
  - byte: the selected lane (LsuAddr[0] ? lo[15:8] : lo[7:0]) extended from bit 7.
- MemRValid outside a *_WAIT state is ignored.
- A requester dropping Req mid-transaction is illegal; the sequence still completes.
- Reset (rst = 0): state = IDLE. All outputs are 0, including Gnt, Valid, Done, Err, MemReq, MemWrite, MemByteEn, MemAddr, MemWData, FetchData and LsuRData. Reset in the middle of an operation abandons the transaction, and any later MemRValid is ignored.

## Timing
- All outputs are registered; none depend combinationally on inputs.
- Gnt pulses in the cycle after the request is sampled, which is the same cycle MemReq first rises.
- Minimum latency with MemReady = 1 and MemRValid one cycle after accept (request sampled in cycle 0):
  - fetch: FetchValid in cycle 3.
  - half/byte read: LsuDone in cycle 4.
  - word read: LsuDone in cycle 6.
  - half/byte write: LsuDone in cycle 2.
  - word write: LsuDone in cycle 3.
  - misaligned: LsuDone with LsuErr in cycle 2.
- After DONE or FETCH_WAIT the block returns to IDLE for one cycle, so there is one dead cycle between transactions. A requester still holding Req is re-arbitrated there.
- MemReq stays high with all address, data and enable fields stable until MemReady; memory wait states stall indefinitely.

## Test plan
- Fetch only, FetchAddr = 0x100, MemRData = 0x4501 -> MemAddr = 0x100, FetchData = 0x4501, FetchValid in cycle 3.
- Simultaneous FetchReq and LsuReq word load at 0x200, memory returns 0xBEEF then 0xDEAD, LSU_PRIORITY = 1 -> LsuGnt first, beats at 0x200 and 0x202, LsuRData = 0xDEADBEEF. Fetch is granted next. Repeat with LSU_PRIORITY = 0 -> fetch first.
- Byte load, LsuAddr = 0x203, MemRData = 0x8034, signed -> MemByteEn = 10, LsuRData = 0xFFFFFF80. Unsigned -> 0x00000080.
- Word store 0x12345678 to 0x300 -> beats (0x300, 0x5678, 11) then (0x302, 0x1234, 11). Byte store 0xAB to 0x301 -> MemWData = 0xABAB, MemByteEn = 10.
- Half load at 0x201 -> LsuDone with LsuErr = 1 in cycle 2 and no MemReq. Word load at 0x202 -> same response.
- MemReady held low for 5 cycles in LO_REQ -> MemReq and fields stable throughout. Assert rst = 0 during LO_WAIT -> all outputs 0, state IDLE, and a later MemRValid produces no LsuDone.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 16-bit memory port between instruction fetch and the LSU.
// Word data accesses are split into two halfword beats; byte/half accesses use lane enables.
// Loads are sign- or zero-extended; misaligned data accesses complete with an error and no
// memory traffic. All outputs are registered.
//
// Ports:
//   clk, rst              clock, synchronous active-low reset
//   fetch_*               fetch requester: req/addr in, gnt/valid pulses and halfword data out
//   lsu_*                 load/store requester: req/write/width/unsigned/addr/wdata in,
//                         gnt/done/err pulses and extended load data out
//   mem_*                 external memory port: req/write/addr/byte_en/wdata out,
//                         ready/rvalid/rdata in
module mem_port_arbiter #(
  parameter bit LsuPriority = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_gnt,
  output logic        fetch_valid,
  output logic [15:0] fetch_data,
  input  logic        lsu_req,
  input  logic        lsu_write,
  input  logic [1:0]  lsu_width,
  input  logic        lsu_unsigned,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_gnt,
  output logic        lsu_done,
  output logic        lsu_err,
  output logic [31:0] lsu_rdata,
  output logic        mem_req,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [1:0]  mem_byte_en,
  output logic [15:0] mem_wdata,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [15:0] mem_rdata
);

  localparam logic [1:0] WidthWord = 2'b01;
  localparam logic [1:0] WidthHalf = 2'b10;
  localparam logic [1:0] WidthByte = 2'b11;

  typedef enum logic [2:0] {
    StIdle, StFetchReq, StFetchWait, StLoReq, StLoWait, StHiReq, StHiWait, StDone
  } state_e;

  state_e      state_q, state_d;
  logic        write_q, write_d, uns_q, uns_d, mis_q, mis_d;
  logic [1:0]  width_q, width_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [15:0] lo_q, lo_d, hi_q, hi_d;

  logic        fetch_gnt_q, fetch_gnt_d, fetch_valid_q, fetch_valid_d;
  logic [15:0] fetch_data_q, fetch_data_d;
  logic        lsu_gnt_q, lsu_gnt_d, lsu_done_q, lsu_done_d, lsu_err_q, lsu_err_d;
  logic [31:0] lsu_rdata_q, lsu_rdata_d;
  logic        mem_req_q, mem_req_d, mem_write_q, mem_write_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [1:0]  mem_byte_en_q, mem_byte_en_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;

  logic        sel_write, misaligned, pick_lsu, pick_fetch;
  logic [1:0]  sel_width;
  logic [31:0] sel_addr, sel_wdata, load_data;
  logic [7:0]  lane;

  always_comb begin
    // In IDLE the memory fields for the first beat come straight from the request inputs,
    // afterwards from the copy latched at grant.
    sel_write = (state_q == StIdle) ? lsu_write : write_q;
    sel_width = (state_q == StIdle) ? lsu_width : width_q;
    sel_addr  = (state_q == StIdle) ? lsu_addr  : addr_q;
    sel_wdata = (state_q == StIdle) ? lsu_wdata : wdata_q;

    unique case (lsu_width)
      WidthWord: misaligned = |lsu_addr[1:0];
      WidthHalf: misaligned = lsu_addr[0];
      default:   misaligned = 1'b0;
    endcase
    pick_lsu   = lsu_req && (LsuPriority || !fetch_req);
    pick_fetch = fetch_req && !pick_lsu;

    lane = addr_q[0] ? lo_q[15:8] : lo_q[7:0];
    unique case (width_q)
      WidthHalf: load_data = {{16{~uns_q & lo_q[15]}}, lo_q};
      WidthByte: load_data = {{24{~uns_q & lane[7]}}, lane};
      default:   load_data = {hi_q, lo_q};
    endcase
  end

  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    uns_d         = uns_q;
    mis_d         = mis_q;
    width_d       = width_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    lo_d          = lo_q;
    hi_d          = hi_q;
    fetch_gnt_d   = 1'b0;
    fetch_valid_d = 1'b0;
    fetch_data_d  = fetch_data_q;
    lsu_gnt_d     = 1'b0;
    lsu_done_d    = 1'b0;
    lsu_err_d     = 1'b0;
    lsu_rdata_d   = lsu_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (pick_lsu) begin
          lsu_gnt_d = 1'b1;
          write_d   = lsu_write;
          uns_d     = lsu_unsigned;
          width_d   = lsu_width;
          addr_d    = lsu_addr;
          wdata_d   = lsu_wdata;
          mis_d     = misaligned;
          state_d   = misaligned ? StDone : StLoReq;
        end else if (pick_fetch) begin
          fetch_gnt_d = 1'b1;
          state_d     = StFetchReq;
        end
      end
      StFetchReq: if (mem_ready) state_d = StFetchWait;
      StFetchWait: begin
        if (mem_rvalid) begin
          fetch_data_d  = mem_rdata;
          fetch_valid_d = 1'b1;
          state_d       = StIdle;
        end
      end
      StLoReq: begin
        if (mem_ready) begin
          if (!write_q) begin
            state_d = StLoWait;
          end else if (width_q == WidthWord) begin
            state_d = StHiReq;
          end else begin
            // Writes report completion on the final accept; DONE only drains.
            lsu_done_d = 1'b1;
            state_d    = StDone;
          end
        end
      end
      StLoWait: begin
        if (mem_rvalid) begin
          lo_d    = mem_rdata;
          state_d = (width_q == WidthWord) ? StHiReq : StDone;
        end
      end
      StHiReq: begin
        if (mem_ready) begin
          if (write_q) begin
            lsu_done_d = 1'b1;
            state_d    = StDone;
          end else begin
            state_d = StHiWait;
          end
        end
      end
      StHiWait: begin
        if (mem_rvalid) begin
          hi_d    = mem_rdata;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
        // Loads and rejected accesses signal completion on leaving DONE.
        if (!write_q || mis_q) begin
          lsu_done_d = 1'b1;
          lsu_err_d  = mis_q;
          if (!write_q) lsu_rdata_d = mis_q ? 32'h0 : load_data;
        end
      end
      default: state_d = StIdle;
    endcase

    // Memory fields are registered from the next state so they are stable for the whole beat.
    mem_req_d     = 1'b0;
    mem_write_d   = 1'b0;
    mem_addr_d    = 32'h0;
    mem_byte_en_d = 2'b00;
    mem_wdata_d   = 16'h0;
    case (state_d)
      StFetchReq: begin
        mem_req_d     = 1'b1;
        mem_addr_d    = fetch_addr & ~32'd1;
        mem_byte_en_d = 2'b11;
      end
      StLoReq: begin
        mem_req_d   = 1'b1;
        mem_write_d = sel_write;
        mem_addr_d  = sel_addr & ~32'd1;
        if (sel_width == WidthByte) begin
          mem_byte_en_d = sel_addr[0] ? 2'b10 : 2'b01;
          mem_wdata_d   = {2{sel_wdata[7:0]}};
        end else begin
          mem_byte_en_d = 2'b11;
          mem_wdata_d   = sel_wdata[15:0];
        end
      end
      StHiReq: begin
        mem_req_d     = 1'b1;
        mem_write_d   = sel_write;
        mem_addr_d    = (sel_addr + 32'd2) & ~32'd1;
        mem_byte_en_d = 2'b11;
        mem_wdata_d   = sel_wdata[31:16];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StIdle;
      write_q       <= 1'b0;
      uns_q         <= 1'b0;
      mis_q         <= 1'b0;
      width_q       <= 2'b00;
      addr_q        <= 32'h0;
      wdata_q       <= 32'h0;
      lo_q          <= 16'h0;
      hi_q          <= 16'h0;
      fetch_gnt_q   <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_data_q  <= 16'h0;
      lsu_gnt_q     <= 1'b0;
      lsu_done_q    <= 1'b0;
      lsu_err_q     <= 1'b0;
      lsu_rdata_q   <= 32'h0;
      mem_req_q     <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_addr_q    <= 32'h0;
      mem_byte_en_q <= 2'b00;
      mem_wdata_q   <= 16'h0;
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      uns_q         <= uns_d;
      mis_q         <= mis_d;
      width_q       <= width_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      lo_q          <= lo_d;
      hi_q          <= hi_d;
      fetch_gnt_q   <= fetch_gnt_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_data_q  <= fetch_data_d;
      lsu_gnt_q     <= lsu_gnt_d;
      lsu_done_q    <= lsu_done_d;
      lsu_err_q     <= lsu_err_d;
      lsu_rdata_q   <= lsu_rdata_d;
      mem_req_q     <= mem_req_d;
      mem_write_q   <= mem_write_d;
      mem_addr_q    <= mem_addr_d;
      mem_byte_en_q <= mem_byte_en_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign fetch_gnt   = fetch_gnt_q;
  assign fetch_valid = fetch_valid_q;
  assign fetch_data  = fetch_data_q;
  assign lsu_gnt     = lsu_gnt_q;
  assign lsu_done    = lsu_done_q;
  assign lsu_err     = lsu_err_q;
  assign lsu_rdata   = lsu_rdata_q;
  assign mem_req     = mem_req_q;
  assign mem_write   = mem_write_q;
  assign mem_addr    = mem_addr_q;
  assign mem_byte_en = mem_byte_en_q;
  assign mem_wdata   = mem_wdata_q;

endmodule
